// File: rtl/tern_matvec_sequencer.sv
// tern_matvec_sequencer: row-serial ternary matrix-vector product with saturating accumulate and valid/ready row output
module tern_matvec_sequencer #(
  parameter int ROWS       = 4096,
  parameter int COLS       = 4096,
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  localparam int CHUNKS    = COLS / LANES,
  localparam int CAW       = $clog2(CHUNKS),
  localparam int RAW       = $clog2(ROWS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [CAW-1:0]                act_rd_addr,
  output logic [RAW+CAW-1:0]            wgt_rd_addr,
  input  logic [LANES*DATA_WIDTH-1:0]   act_rd_data,
  input  logic [LANES*2-1:0]            wgt_rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [RAW-1:0]                out_row,
  output logic signed [ACC_WIDTH-1:0]   out_data,
  output logic                          sat_flag
);
  localparam int SW = DATA_WIDTH + 1 + $clog2(LANES);
  localparam int EW = (ACC_WIDTH > SW ? ACC_WIDTH : SW) + 1;
  localparam logic signed [EW-1:0] MAXV = EW'((64'sd1 <<< (ACC_WIDTH - 1)) - 64'sd1);
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                       r_state, w_next;
  logic [RAW-1:0]               r_row;
  logic [CAW-1:0]               r_chunk;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_sat, r_dv, r_done;
  logic signed [SW-1:0]         w_sum;
  logic signed [EW-1:0]         w_ext;
  logic                         w_hi, w_lo, w_last_chunk, w_last_row, w_hs;
  logic signed [ACC_WIDTH-1:0]  w_acc;

  assign w_last_chunk = r_chunk == CAW'(CHUNKS - 1);
  assign w_last_row   = r_row == RAW'(ROWS - 1);
  assign w_hs         = r_state == OUT && out_ready;

  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;

  // next-state: a start coinciding with done is dropped so a pass never chains silently
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start && !r_done ? RUN : IDLE;
      RUN:     w_next = w_last_chunk ? DRAIN : RUN;
      DRAIN:   w_next = OUT;
      OUT:     w_next = !out_ready ? OUT : w_last_row ? IDLE : RUN;
      default: w_next = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy      = r_state != IDLE;
    rd_en     = r_state == RUN;
    out_valid = r_state == OUT;
  end

  assign done        = r_done;
  assign act_rd_addr = r_chunk;
  assign wgt_rd_addr = {r_row, r_chunk};
  assign out_row     = r_row;
  assign out_data    = r_acc;
  assign sat_flag    = r_sat;

  // ternary lane reduction at full width; negation is done after widening so -(min) is exact
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++)
      w_sum = w_sum + (wgt_rd_data[2*i +: 2] == 2'b01 ?  SW'(signed'(act_rd_data[i*DATA_WIDTH +: DATA_WIDTH])) :
                       wgt_rd_data[2*i +: 2] == 2'b10 ? -SW'(signed'(act_rd_data[i*DATA_WIDTH +: DATA_WIDTH])) : SW'(0));
  end

  // saturating add of the chunk sum into the row accumulator
  always_comb begin
    w_ext = EW'(r_acc) + EW'(w_sum);
    w_hi  = w_ext > MAXV;
    w_lo  = w_ext < MINV;
    w_acc = w_hi ? MAXV[ACC_WIDTH-1:0] : w_lo ? MINV[ACC_WIDTH-1:0] : w_ext[ACC_WIDTH-1:0];
  end

  // datapath: r_dv marks the cycle whose RAM data belongs to a read issued the cycle before
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_row   <= '0;
      r_chunk <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_dv    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_dv   <= r_state == RUN;
      r_done <= w_hs && w_last_row;
      if (r_state == IDLE && w_next == RUN) begin
        r_row   <= '0;
        r_chunk <= '0;
        r_acc   <= '0;
        r_sat   <= 1'b0;
      end else begin
        if (r_state == RUN) r_chunk <= w_last_chunk ? '0 : r_chunk + CAW'(1);
        if (r_dv) begin
          r_acc <= w_acc;
          if (w_hi || w_lo) r_sat <= 1'b1;
        end
        if (w_hs && !w_last_row) begin
          r_row   <= r_row + RAW'(1);
          r_chunk <= '0;
          r_acc   <= '0;
        end
      end
    end
endmodule

// File: tb/tb_tern_matvec_sequencer.sv
// tb_tern_matvec_sequencer: randomized self-checking bench against a behavioural matrix-vector model
module tb_tern_matvec_sequencer;
  localparam int ROWS = 4, COLS = 32, LANES = 8, DW = 8, CHUNKS = 4, TMAX = 200;

  logic clk = 1'b0;
  logic rst, start, out_ready, start8, rdy8;
  logic busy, done, rd_en, out_valid, sat_flag;
  logic [1:0] act_rd_addr, out_row;
  logic [3:0] wgt_rd_addr;
  logic [LANES*DW-1:0] act_d, act_d8;
  logic [LANES*2-1:0] wgt_d, wgt_d8;
  logic signed [19:0] out_data;
  logic busy8, done8, rd8, v8, sat8;
  logic [1:0] aa8, row8;
  logic [3:0] wa8;
  logic signed [7:0] data8;

  logic [LANES*DW-1:0] act_mem [CHUNKS];
  logic [LANES*2-1:0] wgt_mem [ROWS*CHUNKS];

  int n_checks = 0, n_err = 0;
  bit tr_v[TMAX], tr_rd[TMAX], tr_busy[TMAX], tr_done[TMAX], tr_sat[TMAX];
  int tr_row[TMAX], tr_data[TMAX], tr_wa[TMAX], tr_aa[TMAX];
  int hs_row[8], hs_data[8], hs_cyc[8];
  int n_hs, done_at, n_cyc;

  always #5 clk = ~clk;

  tern_matvec_sequencer #(.ROWS(ROWS), .COLS(COLS), .LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(20)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .act_rd_addr(act_rd_addr), .wgt_rd_addr(wgt_rd_addr), .act_rd_data(act_d), .wgt_rd_data(wgt_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data), .sat_flag(sat_flag));

  tern_matvec_sequencer #(.ROWS(ROWS), .COLS(COLS), .LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8), .rd_en(rd8),
    .act_rd_addr(aa8), .wgt_rd_addr(wa8), .act_rd_data(act_d8), .wgt_rd_data(wgt_d8),
    .out_valid(v8), .out_ready(rdy8), .out_row(row8), .out_data(data8), .sat_flag(sat8));

  always_ff @(posedge clk) begin
    if (rd_en) begin
      act_d <= act_mem[act_rd_addr];
      wgt_d <= wgt_mem[wgt_rd_addr];
    end
    if (rd8) begin
      act_d8 <= act_mem[aa8];
      wgt_d8 <= wgt_mem[wa8];
    end
  end

  function automatic int ref_row(input int r, input int accw, output bit sat);
    int acc, s, a, hi, lo;
    logic [1:0] w;
    hi = (1 << (accw - 1)) - 1;
    lo = -(1 << (accw - 1));
    acc = 0;
    sat = 0;
    for (int ch = 0; ch < CHUNKS; ch++) begin
      s = 0;
      for (int l = 0; l < LANES; l++) begin
        a = int'(byte'(act_mem[ch][l*DW +: DW]));
        w = wgt_mem[r*CHUNKS + ch][2*l +: 2];
        s += (w == 2'b01) ? a : (w == 2'b10) ? -a : 0;
      end
      acc += s;
      if (acc > hi) begin acc = hi; sat = 1; end
      if (acc < lo) begin acc = lo; sat = 1; end
    end
    return acc;
  endfunction

  task automatic fill_rand();
    for (int ch = 0; ch < CHUNKS; ch++)
      for (int l = 0; l < LANES; l++) act_mem[ch][l*DW +: DW] = 8'($urandom);
    for (int i = 0; i < ROWS*CHUNKS; i++) wgt_mem[i] = 16'($urandom);
  endtask

  // runs one pass on the 20-bit instance and records a per-cycle trace; index c = value seen just before edge c
  task automatic collect(input int mode, input int stall_row, input int stall_len, input int extra);
    int c, sc;
    n_hs = 0; done_at = -1; sc = 0;
    for (int i = 0; i < TMAX; i++) begin tr_v[i] = 0; tr_rd[i] = 0; tr_busy[i] = 0; tr_done[i] = 0; end
    @(negedge clk); start = 1; out_ready = 1;
    @(negedge clk); start = 0; c = 1;
    while (c < TMAX - 10 && (done_at < 0 || c < done_at + 3)) begin
      tr_v[c] = out_valid; tr_rd[c] = rd_en; tr_busy[c] = busy; tr_done[c] = done; tr_sat[c] = sat_flag;
      tr_row[c] = int'(out_row); tr_data[c] = int'(out_data); tr_wa[c] = int'(wgt_rd_addr); tr_aa[c] = int'(act_rd_addr);
      if (done && done_at < 0) done_at = c;
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && out_valid && int'(out_row) == stall_row && sc < stall_len) begin out_ready = 0; sc++; end
      else out_ready = 1;
      if (out_valid && out_ready && n_hs < 8) begin
        hs_row[n_hs] = int'(out_row); hs_data[n_hs] = int'(out_data); hs_cyc[n_hs] = c; n_hs++;
      end
      start = (c == extra);
      @(negedge clk);
      c++;
    end
    n_cyc = c;
    start = 0; out_ready = 1;
  endtask

  task automatic test_reset();
    rst = 0; start = 0; start8 = 0; out_ready = 1; rdy8 = 1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, rd_en, act_rd_addr, wgt_rd_addr, out_valid, out_row, out_data, sat_flag} !== '0) begin
      n_err++; $display("FAIL reset_outputs got %b want all zero", {busy, done, rd_en, act_rd_addr, wgt_rd_addr, out_valid, out_row, out_data, sat_flag});
    end
    n_checks++;
    if ({busy8, done8, rd8, aa8, wa8, v8, row8, data8, sat8} !== '0) begin
      n_err++; $display("FAIL reset_outputs8 got %b want all zero", {busy8, done8, rd8, aa8, wa8, v8, row8, data8, sat8});
    end
    rst = 1;
  endtask

  task automatic test_ones();
    int nd;
    for (int ch = 0; ch < CHUNKS; ch++) act_mem[ch] = {LANES{8'd1}};
    for (int i = 0; i < ROWS*CHUNKS; i++) wgt_mem[i] = {LANES{2'b01}};
    collect(0, 0, 0, -1);
    n_checks++;
    if (n_hs !== ROWS) begin n_err++; $display("FAIL ones_rows got %0d want %0d", n_hs, ROWS); end
    for (int i = 0; i < n_hs; i++) begin
      n_checks++;
      if (hs_row[i] !== i || hs_data[i] !== 32 || hs_cyc[i] !== 6*(i+1)) begin
        n_err++; $display("FAIL ones_row%0d got row=%0d data=%0d cyc=%0d want row=%0d data=32 cyc=%0d", i, hs_row[i], hs_data[i], hs_cyc[i], i, 6*(i+1));
      end
    end
    nd = 0;
    for (int c = 1; c < n_cyc; c++) nd += tr_done[c];
    n_checks++;
    if (nd !== 1 || done_at !== 25) begin n_err++; $display("FAIL ones_done got count=%0d at=%0d want count=1 at=25", nd, done_at); end
    n_checks++;
    if (done_at > 1 && (tr_busy[done_at] !== 0 || tr_busy[done_at-1] !== 1)) begin
      n_err++; $display("FAIL ones_busy got %0d%0d want 10", tr_busy[done_at-1], tr_busy[done_at]);
    end
  endtask

  task automatic test_negate();
    for (int ch = 0; ch < CHUNKS; ch++) act_mem[ch] = {LANES{8'd3}};
    for (int i = 0; i < ROWS*CHUNKS; i++) wgt_mem[i] = (i / CHUNKS == 2) ? {LANES{2'b11}} : {LANES{2'b10}};
    collect(0, 0, 0, -1);
    n_checks++;
    if (n_hs !== ROWS) begin n_err++; $display("FAIL neg_rows got %0d want %0d", n_hs, ROWS); end
    for (int i = 0; i < n_hs; i++) begin
      n_checks++;
      if (hs_data[i] !== ((i == 2) ? 0 : -96)) begin
        n_err++; $display("FAIL neg_row%0d got %0d want %0d", i, hs_data[i], (i == 2) ? 0 : -96);
      end
    end
    n_checks++;
    if (done_at < 0 || tr_sat[done_at] !== 0) begin n_err++; $display("FAIL neg_sat got done_at=%0d sat=1 want sat=0", done_at); end
  endtask

  task automatic test_mixed();
    int bad, nr;
    bit s;
    for (int ch = 0; ch < CHUNKS; ch++)
      for (int l = 0; l < LANES; l++) act_mem[ch][l*DW +: DW] = (l % 2 == 0) ? 8'd5 : 8'd7;
    for (int i = 0; i < ROWS*CHUNKS; i++)
      for (int l = 0; l < LANES; l++) wgt_mem[i][2*l +: 2] = (l % 2 == 0) ? 2'b01 : 2'b10;
    collect(0, 0, 0, -1);
    for (int i = 0; i < n_hs; i++) begin
      n_checks++;
      if (hs_data[i] !== ref_row(i, 20, s)) begin n_err++; $display("FAIL mixed_row%0d got %0d want %0d", i, hs_data[i], ref_row(i, 20, s)); end
    end
    bad = 0;
    for (int c = 1; c <= 24; c++) if (tr_rd[c] !== ((c - 1) % 6 < 4)) bad++;
    n_checks++;
    if (bad !== 0) begin n_err++; $display("FAIL mixed_rd_pattern got %0d wrong cycles want 0", bad); end
    nr = 0; bad = 0;
    for (int c = 1; c < n_cyc; c++)
      if (tr_rd[c]) begin
        if (tr_wa[c] !== nr || tr_aa[c] !== nr % CHUNKS) bad++;
        nr++;
      end
    n_checks++;
    if (nr !== ROWS*CHUNKS || bad !== 0) begin n_err++; $display("FAIL mixed_addr got reads=%0d bad=%0d want reads=%0d bad=0", nr, bad, ROWS*CHUNKS); end
  endtask

  task automatic test_stall();
    int bad;
    bit s;
    fill_rand();
    collect(2, 1, 5, -1);
    n_checks++;
    if (n_hs !== ROWS) begin n_err++; $display("FAIL stall_rows got %0d want %0d", n_hs, ROWS); end
    for (int i = 0; i < n_hs; i++) begin
      n_checks++;
      if (hs_row[i] !== i || hs_data[i] !== ref_row(i, 20, s)) begin
        n_err++; $display("FAIL stall_row%0d got row=%0d data=%0d want row=%0d data=%0d", i, hs_row[i], hs_data[i], i, ref_row(i, 20, s));
      end
    end
    bad = 0;
    for (int c = 12; c <= 16; c++)
      if (tr_v[c] !== 1 || tr_rd[c] !== 0 || tr_row[c] !== 1 || tr_data[c] !== tr_data[12]) bad++;
    n_checks++;
    if (bad !== 0) begin n_err++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
    n_checks++;
    if (hs_cyc[1] !== 17 || hs_cyc[3] !== 29) begin n_err++; $display("FAIL stall_timing got %0d,%0d want 17,29", hs_cyc[1], hs_cyc[3]); end
  endtask

  task automatic test_back_to_back();
    int nd;
    bit s;
    for (int it = 0; it < 3; it++) begin
      fill_rand();
      collect(1, 0, 0, 3);
      n_checks++;
      if (n_hs !== ROWS) begin n_err++; $display("FAIL b2b%0d_rows got %0d want %0d", it, n_hs, ROWS); end
      for (int i = 0; i < n_hs; i++) begin
        n_checks++;
        if (hs_row[i] !== i || hs_data[i] !== ref_row(i, 20, s)) begin
          n_err++; $display("FAIL b2b%0d_row%0d got row=%0d data=%0d want row=%0d data=%0d", it, i, hs_row[i], hs_data[i], i, ref_row(i, 20, s));
        end
      end
      nd = 0;
      for (int c = 1; c < n_cyc; c++) nd += tr_done[c];
      n_checks++;
      if (nd !== 1) begin n_err++; $display("FAIL b2b%0d_done got %0d want 1", it, nd); end
    end
    collect(0, 0, 0, 25);
    n_checks++;
    if (done_at !== 25 || tr_busy[26] !== 0 || tr_busy[27] !== 0 || tr_rd[26] !== 0) begin
      n_err++; $display("FAIL start_on_done got done_at=%0d busy=%0d%0d rd=%0d want 25 00 0", done_at, tr_busy[26], tr_busy[27], tr_rd[26]);
    end
  endtask

  task automatic test_saturation();
    int nh, c;
    bit s;
    for (int ch = 0; ch < CHUNKS; ch++) act_mem[ch] = {LANES{8'h80}};
    for (int i = 0; i < ROWS*CHUNKS; i++) wgt_mem[i] = {LANES{2'b10}};
    @(negedge clk); start8 = 1;
    @(negedge clk); start8 = 0;
    nh = 0; c = 0;
    while (c < 100 && !done8) begin
      if (v8) begin
        n_checks++;
        if (int'(data8) !== ref_row(nh, 8, s) || int'(data8) !== 127) begin
          n_err++; $display("FAIL sat_row%0d got %0d want %0d", nh, data8, ref_row(nh, 8, s));
        end
        nh++;
      end
      @(negedge clk); c++;
    end
    n_checks++;
    if (nh !== ROWS || !done8) begin n_err++; $display("FAIL sat_rows got %0d done=%0d want %0d done=1", nh, done8, ROWS); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (sat8 !== 1 || busy8 !== 0) begin n_err++; $display("FAIL sat_sticky got sat=%0d busy=%0d want sat=1 busy=0", sat8, busy8); end
    for (int ch = 0; ch < CHUNKS; ch++) act_mem[ch] = '0;
    start8 = 1;
    @(negedge clk); start8 = 0;
    n_checks++;
    if (sat8 !== 0 || busy8 !== 1) begin n_err++; $display("FAIL sat_clear got sat=%0d busy=%0d want sat=0 busy=1", sat8, busy8); end
    c = 0;
    while (c < 100 && !done8) begin @(negedge clk); c++; end
    n_checks++;
    if (!done8 || sat8 !== 0) begin n_err++; $display("FAIL sat_clean_pass got done=%0d sat=%0d want done=1 sat=0", done8, sat8); end
  endtask

  task automatic test_abort();
    int c, bad;
    bit s;
    fill_rand();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    c = 0;
    while (c < 40 && !(out_row == 2'd1 && rd_en)) begin @(negedge clk); c++; end
    n_checks++;
    if (c >= 40) begin n_err++; $display("FAIL abort_reach_row1 got timeout want RUN of row 1"); end
    #2 rst = 0;
    #1;
    n_checks++;
    if ({busy, done, rd_en, act_rd_addr, wgt_rd_addr, out_valid, out_row, out_data, sat_flag} !== '0) begin
      n_err++; $display("FAIL abort_async got %b want all zero", {busy, done, rd_en, act_rd_addr, wgt_rd_addr, out_valid, out_row, out_data, sat_flag});
    end
    @(negedge clk); rst = 1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || rd_en || busy) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_err++; $display("FAIL abort_quiet got %0d active cycles want 0", bad); end
    fill_rand();
    collect(0, 0, 0, 8);
    n_checks++;
    if (n_hs !== ROWS || hs_cyc[0] !== 6 || done_at !== 25) begin
      n_err++; $display("FAIL abort_fresh got rows=%0d first=%0d done_at=%0d want %0d 6 25", n_hs, hs_cyc[0], done_at, ROWS);
    end
    for (int i = 0; i < n_hs; i++) begin
      n_checks++;
      if (hs_data[i] !== ref_row(i, 20, s)) begin n_err++; $display("FAIL abort_fresh_row%0d got %0d want %0d", i, hs_data[i], ref_row(i, 20, s)); end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_negate();
    test_mixed();
    test_stall();
    test_back_to_back();
    test_saturation();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
